// File: rtl/mem_responder_if.sv
// mem_responder_if
//   Request/response bundle between the control sequencer (master) and the
//   memory responder (slave).
//   Read, Write : request strobes, held by the master until accepted
//   address     : word address (low bits of MAR)
//   wdata       : write data (MDR output)
//   rdata       : read data back to MDR Mdatain, holds the last read value
//   Done        : one-cycle completion pulse
//   busy        : request in flight
//   err         : one-cycle pulse after Read and Write were both seen in idle
interface mem_responder_if #(
    parameter int ADDR_W = 9
);
    logic              Read;
    logic              Write;
    logic [ADDR_W-1:0] address;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              Done;
    logic              busy;
    logic              err;

    modport master (
        output Read, Write, address, wdata,
        input  rdata, Done, busy, err
    );

    modport slave (
        input  Read, Write, address, wdata,
        output rdata, Done, busy, err
    );
endinterface

// File: rtl/mem_responder.sv
// mem_responder
//   Memory-side responder: accepts a Read or Write strobe in idle, waits a
//   fixed LATENCY edges, then performs the access on an internal
//   2^ADDR_W x 32 RAM and pulses Done for one cycle.
//   Ports:
//     clock : system clock, rising edge
//     clear : synchronous active-low reset
//     bus   : mem_responder_if slave modport (strobes, address, data,
//             rdata, Done, busy, err)
//   Parameters:
//     ADDR_W  : word address width
//     LATENCY : edges from acceptance to the access edge (1..15)
//
//   state | meaning
//   IDLE  | ready, sampling strobes
//   WAIT  | request latched, counting down to the access edge
//   RESP  | access done, Done high for this cycle
module mem_responder #(
    parameter int ADDR_W  = 9,
    parameter int LATENCY = 2
) (
    input  logic clock,
    input  logic clear,
    mem_responder_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t            state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic              accept;
    logic              conflict;
    logic              access;

    logic              op_wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              err_q;

    logic [31:0]       mem [2**ADDR_W];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        conflict  = 1'b0;
        access    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.Read && bus.Write) begin
                    conflict = 1'b1;
                end else if (bus.Read || bus.Write) begin
                    accept    = 1'b1;
                    cnt_nxt   = CNT_LOAD;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    access    = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            err_q <= conflict;
            if (access && !op_wr_q) begin
                rdata_q <= mem[addr_q];
            end
        end
    end

    // Request capture; later changes on the bus do not affect the access.
    always_ff @(posedge clock) begin
        if (accept) begin
            op_wr_q <= bus.Write;
            addr_q  <= bus.address;
            wdata_q <= bus.wdata;
        end
    end

    // RAM is never reset. Gating on clear drops a write whose access edge
    // coincides with reset.
    always_ff @(posedge clock) begin
        if (clear && access && op_wr_q) begin
            mem[addr_q] <= wdata_q;
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.err   = err_q;
    assign bus.Done  = (state == RESP);
    assign bus.busy  = (state != IDLE);

endmodule
